// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port (data valid one cycle after read) into a 3-deep queue and
// presents it as a valid/ready stream with BURST_LEN framing; FIFO_READER_CNT_EN adds beat_cnt.
module fifo_stream_reader #(
  parameter int DATA_WITH = 16,
  parameter int BURST_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 empty_flag,
  output logic                 read,
  input  logic [DATA_WITH-1:0] data_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_WITH-1:0] m_data,
  output logic                 m_last
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [31:0]          beat_cnt
`endif
);

  localparam int DEPTH = 3;
  localparam logic [15:0] BURST_LAST = 16'(BURST_LEN - 1);

  logic [DATA_WITH-1:0] q_data_reg  [DEPTH];
  logic [DATA_WITH-1:0] q_data_next [DEPTH];
  logic                 q_last_reg  [DEPTH];
  logic                 q_last_next [DEPTH];
  logic [1:0]           occ_reg, occ_next;
  logic                 inflight_reg;
  logic [15:0]          burst_cnt_reg, burst_cnt_next;
  logic                 push, pop, push_tag;
  logic [1:0]           wr_idx;

  assign m_valid  = (occ_reg != 2'd0);
  assign m_data   = q_data_reg[0];
  assign m_last   = q_last_reg[0];
  assign push     = inflight_reg;
  assign pop      = m_valid && m_ready;
  assign push_tag = (burst_cnt_reg == BURST_LAST);
  assign wr_idx   = occ_reg - {1'b0, pop};

  // The word already in flight is counted as occupied, so the queue can never
  // overflow; m_ready is deliberately kept out of this path.
  assign read = !rst && !empty_flag && (({1'b0, occ_reg} + {2'b00, inflight_reg}) < 3'd3);

  // Head is slot 0; a pop shifts everything down, a push lands just past the survivors.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [DATA_WITH-1:0] kept_data;
      logic                 kept_last;
      if (gi < DEPTH - 1) begin : g_shift
        assign kept_data = pop ? q_data_reg[gi+1] : q_data_reg[gi];
        assign kept_last = pop ? q_last_reg[gi+1] : q_last_reg[gi];
      end else begin : g_tail
        assign kept_data = q_data_reg[gi];
        assign kept_last = q_last_reg[gi];
      end
      assign q_data_next[gi] = (push && wr_idx == 2'(gi)) ? data_out : kept_data;
      assign q_last_next[gi] = (push && wr_idx == 2'(gi)) ? push_tag : kept_last;
    end
  endgenerate

  assign occ_next = occ_reg + {1'b0, push} - {1'b0, pop};

  // Burst position only advances on pushed words, so FIFO gaps simply pause it.
  always_comb begin
    burst_cnt_next = burst_cnt_reg;
    if (push) begin
      burst_cnt_next = push_tag ? 16'd0 : burst_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg       <= '0;
      inflight_reg  <= 1'b0;
      burst_cnt_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data_reg[i] <= '0;
        q_last_reg[i] <= 1'b0;
      end
    end else begin
      occ_reg       <= occ_next;
      inflight_reg  <= read;
      burst_cnt_reg <= burst_cnt_next;
      q_data_reg    <= q_data_next;
      q_last_reg    <= q_last_next;
    end
  end

`ifdef FIFO_READER_CNT_EN
  logic [31:0] beat_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_reg <= '0;
    end else if (pop) begin
      beat_cnt_reg <= beat_cnt_reg + 32'd1;
    end
  end

  assign beat_cnt = beat_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: FIFO model, stream table, and corner sequences
// (back-pressure fill, reset mid-stream, latency, BURST_LEN=1, optional FIFO_READER_CNT_EN).
module tb_fifo_stream_reader;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, empty_flag, read, m_valid, m_ready, m_last;
  logic [W-1:0] data_out = '0;
  logic [W-1:0] m_data;
`ifdef FIFO_READER_CNT_EN
  logic [31:0]  beat_cnt;
`endif

  // FIFO model with one-cycle read latency
  logic [W-1:0] mem [256];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  logic         hold, flush_req;
  assign empty_flag = hold || (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (flush_req) rd_ptr <= wr_ptr;
    else if (read) begin
      data_out <= mem[rd_ptr % 256];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  fifo_stream_reader #(.DATA_WITH(W), .BURST_LEN(32)) dut (
    .clk(clk), .rst(rst), .empty_flag(empty_flag), .read(read), .data_out(data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef FIFO_READER_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  // Second instance with BURST_LEN=1, fed by its own 4-word source
  logic         read1, empty1, m_valid1, m_last1, hold1, m_ready1;
  logic [W-1:0] data1 = '0;
  logic [W-1:0] m_data1;
  int           cnt1 = 0;
`ifdef FIFO_READER_CNT_EN
  logic [31:0]  beat_cnt1;
`endif
  assign empty1 = hold1 || (cnt1 >= 4);
  always @(posedge clk) begin
    if (read1) begin
      data1 <= W'(200 + cnt1);
      cnt1  <= cnt1 + 1;
    end
  end

  fifo_stream_reader #(.DATA_WITH(W), .BURST_LEN(1)) u_len1 (
    .clk(clk), .rst(rst), .empty_flag(empty1), .read(read1), .data_out(data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1)
`ifdef FIFO_READER_CNT_EN
    , .beat_cnt(beat_cnt1)
`endif
  );

  // Monitor: records every beat that the next rising edge will accept
  logic [W-1:0] got_data[$];
  logic         got_last[$];
  int           got_cyc[$];
  logic [W-1:0] got1_data[$];
  logic         got1_last[$];
  int           cyc = 0;
  int           viol = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_last.push_back(m_last);
      got_cyc.push_back(cyc);
    end
    if (m_valid1 && m_ready1) begin
      got1_data.push_back(m_data1);
      got1_last.push_back(m_last1);
    end
    if ((read && empty_flag) || (read1 && empty1)) viol = viol + 1;
  end

  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; hold = 1'b1; flush_req = 1'b1; m_ready = 1'b0;
    tick();
    @(negedge clk);
    check("rst_read", read, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
`ifdef FIFO_READER_CNT_EN
    check("rst_beat_cnt", beat_cnt, 0);
`endif
    tick();
    rst = 1'b0; flush_req = 1'b0;
  endtask

  task automatic preload(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 256] = W'(base + i);
      wr_ptr++;
    end
  endtask

  task automatic collect(input int b, input int n, input bit toggle, input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (toggle) m_ready = !m_ready;
      if (got_data.size() - b >= n) break;
    end
    check("beat_count", got_data.size() - b, n);
  endtask

  typedef struct {
    int base;
    int n;
    bit toggle;
    int exp_lasts;
    int exp_span;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int b, nl, nr, stab_bad, v0, lim;
    rst = 1'b1; hold = 1'b1; hold1 = 1'b1; flush_req = 1'b0;
    m_ready = 1'b0; m_ready1 = 1'b1;

    vecs[0] = '{base: 1,   n: 32, toggle: 1'b0, exp_lasts: 1, exp_span: 31};
    vecs[1] = '{base: 1,   n: 40, toggle: 1'b1, exp_lasts: 1, exp_span: 78};
    vecs[2] = '{base: 500, n: 64, toggle: 1'b0, exp_lasts: 2, exp_span: 63};

    do_reset();

    // Table: preload, release, stream, compare order, framing and throughput
    for (int k = 0; k < 3; k++) begin
      do_reset();
      v0 = viol;
      b  = got_data.size();
      preload(vecs[k].base, vecs[k].n);
      m_ready = 1'b1;
      hold    = 1'b0;
      collect(b, vecs[k].n, vecs[k].toggle, 4 * vecs[k].n + 20);
      lim = got_data.size() - b;
      if (lim > vecs[k].n) lim = vecs[k].n;
      nl = 0;
      for (int i = 0; i < lim; i++) begin
        check($sformatf("c%0d_data%0d", k, i), got_data[b+i], vecs[k].base + i);
        check($sformatf("c%0d_last%0d", k, i), got_last[b+i], (i % 32) == 31);
        nl += int'(got_last[b+i]);
      end
      check($sformatf("c%0d_nlast", k), nl, vecs[k].exp_lasts);
      if (lim > 0) check($sformatf("c%0d_span", k), got_cyc[b+lim-1] - got_cyc[b], vecs[k].exp_span);
      check($sformatf("c%0d_read_when_empty", k), viol - v0, 0);
`ifdef FIFO_READER_CNT_EN
      @(negedge clk);
      if (vecs[k].n == 32) check("beat_cnt_32", beat_cnt, 32);
`endif
      $display("case %0d: base=%0d beats=%0d toggle=%0d lasts=%0d", k, vecs[k].base, lim, vecs[k].toggle, nl);
    end

    // First-word latency: read in cycle N, beat valid from cycle N+2
    do_reset();
    hold = 1'b0;
    preload(77, 1);
    @(negedge clk); check("lat_read_n", read, 1);
    tick();
    @(negedge clk); check("lat_valid_n1", m_valid, 0); check("lat_read_empty", read, 0);
    tick();
    @(negedge clk); check("lat_valid_n2", m_valid, 1); check("lat_data_n2", m_data, 77);
    check("lat_last_n2", m_last, 0);
    m_ready = 1'b1;
    tick(); tick();
    $display("latency: word 77 delivered");

    // Back-pressure: queue fills to 3, read high for exactly 3 cycles, head stable
    do_reset();
    preload(1, 8);
    hold = 1'b0;
    nr = 0; stab_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (read) nr++;
      if (m_valid && m_data !== 1) stab_bad++;
      tick();
    end
    @(negedge clk);
    check("bp_read_cycles", nr, 3);
    check("bp_occ", dut.occ_reg, 3);
    check("bp_valid", m_valid, 1);
    check("bp_head", m_data, 1);
    check("bp_stable", stab_bad, 0);
    b = got_data.size();
    m_ready = 1'b1;
    collect(b, 8, 1'b0, 40);
    for (int i = 0; i < 8 && b + i < got_data.size(); i++) check($sformatf("bp_data%0d", i), got_data[b+i], i + 1);
    $display("backpressure: read_cycles=%0d drained=%0d", nr, got_data.size() - b);

    // Reset mid-stream with 3 queued, then a fresh full burst
    do_reset();
    preload(1, 40);
    b = got_data.size();
    m_ready = 1'b1;
    hold = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (got_data.size() - b >= 5) begin
        m_ready = 1'b0;
        break;
      end
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (dut.occ_reg == 2'd3) break;
    end
    @(negedge clk);
    check("mid_accepted", got_data.size() - b, 5);
    check("mid_occ", dut.occ_reg, 3);
    check("mid_head", m_data, 6);
    rst = 1'b1; hold = 1'b1; flush_req = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_read", read, 0);
    tick();
    rst = 1'b0; flush_req = 1'b0;
    b = got_data.size();
    preload(100, 32);
    m_ready = 1'b1;
    hold = 1'b0;
    collect(b, 32, 1'b0, 100);
    for (int i = 0; i < 32 && b + i < got_data.size(); i++) begin
      check($sformatf("re_data%0d", i), got_data[b+i], 100 + i);
      check($sformatf("re_last%0d", i), got_last[b+i], i == 31);
    end
    $display("reset mid-stream: refill beats=%0d", got_data.size() - b);

    // BURST_LEN=1: every beat is last
    hold1 = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (got1_data.size() >= 4) break;
    end
    tick(); tick();
    check("len1_count", got1_data.size(), 4);
    for (int i = 0; i < 4 && i < got1_data.size(); i++) begin
      check($sformatf("len1_data%0d", i), got1_data[i], 200 + i);
      check($sformatf("len1_last%0d", i), got1_last[i], 1);
    end
    $display("burst_len1: beats=%0d", got1_data.size());

    check("read_when_empty_total", viol, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
